rega_load_arbiter: RTL and testbench
====================================

# rega_load_arbiter

Round-robin arbiter that shares the single load port of register A (`load_a`/`data_in_a`) among NUM_REQ requesters. It supports multi-beat bursts with ownership lock and an idle timeout. It tracks each accepted load through register A's PIPE_DEPTH-stage output pipeline and raises a tagged response when that load's data reaches the register output. It sits between the decode/issue logic and register A.

## Interface
- DATA_WIDTH, 32, width of one load word.
- NUM_REQ, 4, number of requesters (≥2).
- PIPE_DEPTH, 2, register A latency from load edge to the data output.
- BURST_TIMEOUT, 16, idle cycles allowed in a burst before forced release (≥1).
- ID_WIDTH, $clog2(NUM_REQ), derived; not to be overridden.

Ports:
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  NUM_REQ  requester i has a word.
- req_data  in  NUM_REQ*DATA_WIDTH  word i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_last  in  NUM_REQ  beat is final of its burst (1 = single-beat).
- req_ready  out  NUM_REQ  one-hot or zero; combinational accept for requester i.
- load_a  out  1  registered load strobe to register A.
- data_in_a  out  DATA_WIDTH  registered load data to register A.
- rsp_valid  out  1  tracked load now visible at register A output.
- rsp_id  out  ID_WIDTH  requester index of that load.
- busy  out  1  state OWN or any load in flight.

## Operation
- Handshake: a beat transfers in a cycle where req_valid[i] && req_ready[i]. Requesters hold data/last stable until transfer.
- States: IDLE, OWN. State, owner (ID_WIDTH), rr_ptr (ID_WIDTH), idle_cnt, tracker shift register (PIPE_DEPTH entries of {valid,id}).
- IDLE behaviour:
  - req_ready goes to the first valid requester scanning from rr_ptr upward, with wrap-around.
  - If the accepted beat has last=1: stay IDLE, rr_ptr <= winner+1 (mod NUM_REQ).
  - If last=0: go to OWN, owner <= winner, idle_cnt <= 0.
- OWN behaviour:
  - Only req_ready[owner] may assert, equal to req_valid[owner]. Other requesters are stalled.
  - Owner beat with last=1: go to IDLE, rr_ptr <= owner+1.
  - Owner beat with last=0: idle_cnt <= 0.
  - Owner not valid: idle_cnt++. On reaching BURST_TIMEOUT, go to IDLE, rr_ptr <= owner+1, no beat issued that cycle.
- Issue: on transfer in cycle N, load_a=1 and data_in_a=word in cycle N+1. Otherwise load_a=0 and data_in_a holds its last value.
- Tracking: a transfer in cycle N produces rsp_valid=1 with rsp_id=i in cycle N+1+PIPE_DEPTH, for exactly one cycle. Back-to-back transfers give back-to-back responses in order; no loss.
- Wrap-around: rr_ptr = NUM_REQ-1 followed by +1 gives 0.
- Reset mid-operation: in-flight responses are dropped, and any burst is abandoned without a response.

## Timing
- Reset values: load_a=0, data_in_a=0, rsp_valid=0, rsp_id=0, busy=0, req_ready=0. State IDLE, rr_ptr=0, owner=0, idle_cnt=0, tracker cleared.
- req_ready is combinational from req_valid, state, rr_ptr and owner. It does not depend on req_data or req_last.
- Throughput: one beat per cycle sustained. Between a burst's end and the next grant there is no bubble, because IDLE arbitration is combinational in the following cycle.
- Load latency is 1 cycle; response latency is 1+PIPE_DEPTH cycles (3 at default).
- Simultaneous events:
  - Timeout and an owner beat in the same cycle: the beat wins and resets idle_cnt.
  - Deassertion of reset: first grant possible in the first cycle after the release edge.
- busy is high from the cycle after the first transfer until the cycle after the last rsp_valid, and throughout OWN.

## Test plan
- Reset, then req_valid=4'b0001 with req_last=1 and data 0xA5A5_0001 in cycle 0 → req_ready=4'b0001 in cycle 0; load_a=1 and data_in_a=0xA5A5_0001 in cycle 1; rsp_valid=1 and rsp_id=0 in cycle 3.
- All four requesters valid with single beats, held continuously → grants in order 0,1,2,3,0 on consecutive cycles; rsp_id sequence 0,1,2,3,0 starting at cycle 3.
- Requester 2 sends a 3-beat burst (last on beat 3) while requester 1 is valid → ready only to 2 for 3 transfers; requester 1 granted on the next cycle (rr_ptr=3 wraps to 0, then 1 wins); responses in order 2,2,2,1.
- Requester 3 sends last=0 then drops valid for 16 cycles → return to IDLE after the 16th idle cycle; rr_ptr=0; requester 0 granted next cycle; no load issued during the timeout.
- Assert reset asynchronously one cycle after two back-to-back transfers → load_a, rsp_valid and busy go 0 immediately; no rsp_valid after release; next grant starts from requester 0.

Source files
------------

// File: rtl/rega_load_arbiter.sv
// Round-robin arbiter for register A's single load port, with burst ownership,
// idle-timeout release and a tagged response when the load reaches A's output.
module rega_load_arbiter #(
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_REQ       = 4,
  parameter int PIPE_DEPTH    = 2,
  parameter int BURST_TIMEOUT = 16,
  localparam int ID_WIDTH     = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          load_a,
  output logic [DATA_WIDTH-1:0]         data_in_a,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic                          busy
);

  localparam int CNT_W = $clog2(BURST_TIMEOUT + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, OWN = 1'b1} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   owner;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [CNT_W-1:0]      idle_cnt;
  logic [PIPE_DEPTH-1:0] trk_valid;
  logic [ID_WIDTH-1:0]   trk_id [PIPE_DEPTH];

  logic [NUM_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0]   winner;
  logic [ID_WIDTH-1:0]   scan_idx;
  logic                  xfer;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  timeout_hit;
  logic                  own_next;

  function automatic logic [ID_WIDTH-1:0] next_id(input logic [ID_WIDTH-1:0] id);
    if (id == ID_WIDTH'(NUM_REQ - 1)) begin
      next_id = ID_WIDTH'(0);
    end else begin
      next_id = id + ID_WIDTH'(1);
    end
  endfunction

  // Grant selection: owner only while bursting, else first valid from rr_ptr upward
  always_comb begin
    winner   = owner;
    grant    = NUM_REQ'(0);
    scan_idx = rr_ptr;
    if (state == OWN) begin
      winner        = owner;
      grant[owner]  = req_valid[owner];
    end else begin
      // scanning highest offset first leaves the lowest-offset valid requester as winner
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_idx = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
        winner   = req_valid[scan_idx] ? scan_idx : winner;
      end
      grant = (|req_valid) ? (NUM_REQ'(1) << winner) : NUM_REQ'(0);
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;
  assign sel_last  = req_last[winner];
  assign sel_data  = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];

  // Burst continuation and timeout decode for the next state
  always_comb begin
    timeout_hit = 1'b0;
    own_next    = 1'b0;
    if (state == OWN) begin
      if (xfer) begin
        own_next = !sel_last;
      end else begin
        timeout_hit = (idle_cnt == CNT_W'(BURST_TIMEOUT - 1));
        own_next    = !timeout_hit;
      end
    end else begin
      own_next = xfer && !sel_last;
    end
  end

  // Arbitration FSM, load issue, response tracker and busy flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= ID_WIDTH'(0);
      rr_ptr    <= ID_WIDTH'(0);
      idle_cnt  <= CNT_W'(0);
      load_a    <= 1'b0;
      data_in_a <= DATA_WIDTH'(0);
      trk_valid <= PIPE_DEPTH'(0);
      for (int i = 0; i < PIPE_DEPTH; i++) begin
        trk_id[i] <= ID_WIDTH'(0);
      end
      rsp_valid <= 1'b0;
      rsp_id    <= ID_WIDTH'(0);
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer && sel_last) begin
            rr_ptr <= next_id(winner);
          end else if (xfer) begin
            state    <= OWN;
            owner    <= winner;
            idle_cnt <= CNT_W'(0);
          end else begin
            state <= IDLE;
          end
        end
        OWN: begin
          if (xfer) begin
            idle_cnt <= CNT_W'(0);
            if (sel_last) begin
              state  <= IDLE;
              rr_ptr <= next_id(owner);
            end else begin
              state <= OWN;
            end
          end else if (timeout_hit) begin
            state    <= IDLE;
            rr_ptr   <= next_id(owner);
            idle_cnt <= CNT_W'(0);
          end else begin
            idle_cnt <= idle_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase

      load_a <= xfer;
      if (xfer) begin
        data_in_a <= sel_data;
      end else begin
        data_in_a <= data_in_a;
      end

      trk_valid[0] <= xfer;
      trk_id[0]    <= winner;
      for (int i = 1; i < PIPE_DEPTH; i++) begin
        trk_valid[i] <= trk_valid[i-1];
        trk_id[i]    <= trk_id[i-1];
      end
      rsp_valid <= trk_valid[PIPE_DEPTH-1];
      rsp_id    <= trk_id[PIPE_DEPTH-1];

      busy <= own_next | xfer | (|trk_valid);
    end
  end

endmodule

// File: tb/tb_rega_load_arbiter.sv
// Randomized bench for rega_load_arbiter against a cycle-level behavioural model
// of arbitration, bursts, timeout, load/response latency and busy.
module tb_rega_load_arbiter;

  localparam int DW   = 32;
  localparam int N    = 4;
  localparam int PD   = 2;
  localparam int TO   = 16;
  localparam int IDW  = $clog2(N);
  localparam int NCYC = 2100;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_last = '0;
  logic [N-1:0]    req_ready;
  logic            load_a;
  logic [DW-1:0]   data_in_a;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic            busy;

  rega_load_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(N), .PIPE_DEPTH(PD), .BURST_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .load_a(load_a), .data_in_a(data_in_a),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  int cur_cyc  = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cur_cyc, obs, exp);
    end
  endtask

  // requester-side stimulus state
  bit          v   [N];
  bit          l   [N];
  logic [31:0] d   [N];
  int          rem [N];
  int          gap [N];

  // model state and expectations indexed by cycle
  int          own, rr, idle;
  bit          exp_load [NCYC+8];
  logic [31:0] exp_data [NCYC+8];
  bit          exp_rsp  [NCYC+8];
  int          exp_id   [NCYC+8];
  bit          exp_busy [NCYC+8];
  logic [31:0] exp_din;

  task automatic clear_model();
    own = -1; rr = 0; idle = 0; exp_din = 32'd0;
    for (int i = 0; i < NCYC + 8; i++) begin
      exp_load[i] = 1'b0; exp_data[i] = 32'd0; exp_rsp[i] = 1'b0;
      exp_id[i] = 0; exp_busy[i] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; l[i] = 1'b0; d[i] = 32'd0; rem[i] = 0; gap[i] = 0;
    end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_last[i]           = l[i];
      req_data[i*DW +: DW]  = d[i];
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_load"}, 64'(load_a), 64'd0);
    check_val({tag, "_din"}, 64'(data_in_a), 64'd0);
    check_val({tag, "_rsp"}, 64'(rsp_valid), 64'd0);
    check_val({tag, "_rspid"}, 64'(rsp_id), 64'd0);
    check_val({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    clear_model();
    apply_inputs();
    #1;
    check_val("async_rst_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b0;
  endtask

  initial begin
    int g_prev;
    int g;
    clear_model();
    apply_inputs();
    #2;
    check_reset_outputs("por");
    check_val("por_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    g_prev = -1;

    for (int c = 0; c < NCYC; c++) begin
      cur_cyc = c;
      @(posedge clk);
      #1;
      if (c % 700 == 699) begin
        do_reset();
        g_prev = -1;
        continue;
      end

      // requester behaviour: hold until transfer, then next beat after an optional gap
      for (int i = 0; i < N; i++) begin
        if (v[i] && g_prev == i) begin
          v[i] = 1'b0;
          if (l[i]) rem[i] = 0;
          else rem[i] = rem[i] - 1;
          if (rem[i] == 0) gap[i] = $urandom_range(0, 2);
          else gap[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 20) : 0;
        end
        if (!v[i]) begin
          if (gap[i] > 0) begin
            gap[i]--;
          end else begin
            if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
            v[i] = 1'b1;
            d[i] = $urandom;
            l[i] = (rem[i] == 1);
          end
        end
      end
      apply_inputs();

      @(negedge clk);
      // model arbitration for this cycle
      g = -1;
      if (own >= 0) begin
        if (v[own]) g = own;
      end else begin
        for (int k = 0; k < N && g < 0; k++) begin
          if (v[(rr + k) % N]) g = (rr + k) % N;
        end
      end

      check_val("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
      check_val("load_a", 64'(load_a), 64'(exp_load[c]));
      if (exp_load[c]) exp_din = exp_data[c];
      check_val("data_in_a", 64'(data_in_a), 64'(exp_din));
      check_val("rsp_valid", 64'(rsp_valid), 64'(exp_rsp[c]));
      if (exp_rsp[c]) check_val("rsp_id", 64'(rsp_id), 64'(exp_id[c]));
      check_val("busy", 64'(busy), 64'(exp_busy[c]));

      // model state update
      if (own < 0) begin
        if (g >= 0) begin
          if (l[g]) rr = (g + 1) % N;
          else begin own = g; idle = 0; end
        end
      end else begin
        if (g >= 0) begin
          idle = 0;
          if (l[g]) begin rr = (g + 1) % N; own = -1; end
        end else begin
          idle++;
          if (idle == TO) begin rr = (own + 1) % N; own = -1; idle = 0; end
        end
      end
      if (g >= 0) begin
        exp_load[c+1]    = 1'b1;
        exp_data[c+1]    = d[g];
        exp_rsp[c+1+PD]  = 1'b1;
        exp_id[c+1+PD]   = g;
        for (int t = c + 1; t <= c + 1 + PD; t++) exp_busy[t] = 1'b1;
      end
      if (own >= 0) exp_busy[c+1] = 1'b1;
      g_prev = g;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
